// File: rtl/ahb_lite_ram_slave.sv
// rtl/ahb_lite_ram_slave.sv - AHB-Lite RAM slave with programmable wait states
// Rejects misaligned, oversized or out-of-range transfers with a two-cycle ERROR response.
module ahb_lite_ram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] widx_r;
  logic [1:0]           lane_r;
  logic [2:0]           size_r;
  logic                 write_r;
  logic [31:0]          mem [2**ADDR_BITS];

  logic                 accept;
  logic                 bad;
  logic [3:0]           be;
  logic                 wr_en;
  logic [31:0]          wr_word;
  logic [31:0]          fwd_word;
  logic [ADDR_BITS-1:0] widx_in;
  logic                 unused_burst;

  // Bursts are treated as independent single transfers.
  assign unused_burst = ^HBURST;

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign widx_in = HADDR[ADDR_BITS+1:2];
  assign wr_en   = HRESETn && (state == S_DONE) && write_r;

  always_comb begin
    bad = (HADDR >> (ADDR_BITS + 2)) != 32'd0;
    case (HSIZE)
      3'd0:    ;
      3'd1:    if (HADDR[0]) bad = 1'b1;
      3'd2:    if (HADDR[1:0] != 2'b00) bad = 1'b1;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    case (size_r)
      3'd0:    be[lane_r] = 1'b1;
      3'd1:    be = lane_r[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    wr_word = mem[widx_r];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // A zero-wait read accepted while a write retires sees the merged word.
  assign fwd_word = (wr_en && (widx_in == widx_r)) ? wr_word : mem[widx_in];

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[widx_r] <= wr_word;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      HREADY  <= 1'b1;
      HRESP   <= 1'b0;
      HRDATA  <= '0;
      cnt     <= '0;
      widx_r  <= '0;
      lane_r  <= '0;
      size_r  <= '0;
      write_r <= 1'b0;
    end else begin
      HRDATA <= '0;
      case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= S_DONE;
            HREADY <= 1'b1;
            if (!write_r) HRDATA <= mem[widx_r];
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          HREADY <= 1'b1;
          HRESP  <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          HREADY <= 1'b1;
          HRESP  <= 1'b0;
          if (accept) begin
            widx_r  <= widx_in;
            lane_r  <= HADDR[1:0];
            size_r  <= HSIZE;
            write_r <= HWRITE;
            if (bad) begin
              state  <= S_ERR1;
              HREADY <= 1'b0;
              HRESP  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= S_DONE;
              if (!HWRITE) HRDATA <= fwd_word;
            end else begin
              state  <= S_WAIT;
              HREADY <= 1'b0;
              cnt    <= 4'(WAIT_STATES);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// tb/tb_ahb_lite_ram_slave.sv - scoreboard bench for ahb_lite_ram_slave at 0, 1 and 3 wait states
module tb_ahb_lite_ram_slave;
  localparam int AB   = 10;
  localparam int NDUT = 3;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [31:0]     haddr, hwdata;
  logic [2:0]      hburst, hsize;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [NDUT-1:0] hsel;
  logic [31:0]     hrdata [NDUT];
  logic [NDUT-1:0] hready, hresp;

  int          cur = 0;
  logic        m_ready, m_resp;
  logic [31:0] m_rdata;
  assign m_ready = hready[cur];
  assign m_resp  = hresp[cur];
  assign m_rdata = hrdata[cur];

  int          checks = 0, errors = 0, cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [NDUT][4096];
  logic [31:0] pend_wd;
  bit          mon_en = 0;
  int          outstanding = 0, lows = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_lite_ram_slave #(
      .ADDR_BITS  (AB),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .HCLK   (hclk),
      .HRESETn(hresetn),
      .HADDR  (haddr),
      .HBURST (hburst),
      .HSEL   (hsel[g]),
      .HSIZE  (hsize),
      .HTRANS (htrans),
      .HWDATA (hwdata),
      .HWRITE (hwrite),
      .HRDATA (hrdata[g]),
      .HREADY (hready[g]),
      .HRESP  (hresp[g])
    );
  end

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc++;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
    return a >= 32'(4 << AB);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[cur][(a & ~32'd3) + 32'(i)];
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    for (int i = 0; i < (1 << s); i++)
      ref_mem[cur][a + 32'(i)] = wd[8*((a + 32'(i)) % 4) +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (t=%0t)", name, cur, act, req, $time);
    end
  endtask

  // Called at the start of a cycle; holds the address phase until the slave is ready.
  task automatic present(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic [2:0] s, input logic w, input logic [31:0] wd, input bit track);
    int   guard;
    exp_t e;
    bit   ill;
    hsel = '0;
    if (sel) hsel[cur] = 1'b1;
    htrans = tr; haddr = a; hsize = s; hwrite = w;
    hburst = 3'($urandom_range(0, 7));
    hwdata = pend_wd;
    guard  = 0;
    while (!m_ready && guard < 40) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (guard >= 40) chk("hready_timeout", 32'(m_ready), 32'd1);
    if (sel && tr[1] && track) begin
      ill     = is_illegal(a, s);
      e.resp  = ill;
      e.stall = ill ? 1 : ws_of(cur);
      e.rdata = (!ill && !w) ? ref_read(a) : 32'd0;
      if (!ill && w) ref_write(a, s, wd);
      exp_q.push_back(e);
    end
    pend_wd = w ? wd : $urandom;
    @(posedge hclk); #1;
  endtask

  task automatic drain();
    repeat (2) present(1'b0, 2'b00, 32'd0, 3'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic rand_xfer();
    int          r;
    logic [2:0]  s;
    logic [31:0] a;
    r = $urandom_range(0, 99);
    s = 3'($urandom_range(0, 2));
    a = 32'($urandom_range(0, 127));
    if (r < 6) s = 3'($urandom_range(3, 7));
    else if (r < 12) a = a + 32'h1000 + (($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 : 32'd0);
    else if (r >= 18) a = a & ~((32'd1 << s) - 32'd1);
    if (r >= 92) present(1'b1, 2'($urandom_range(0, 1)), a, s, 1'($urandom), $urandom, 1'b1);
    present(1'b1, 2'($urandom_range(2, 3)), a, s, 1'($urandom), $urandom, 1'b1);
  endtask

  // Monitor: pops one expectation per completed data phase, checks idle/stall cycles otherwise.
  always @(negedge hclk) begin
    if (mon_en) begin
      if (outstanding != 0) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("hrdata", m_rdata, mon_e.rdata);
            chk("hresp", 32'(m_resp), 32'(mon_e.resp));
            chk("stall_cycles", 32'(lows), 32'(mon_e.stall));
          end
          lows = 0;
        end else begin
          chk("stall_hrdata", m_rdata, 32'd0);
          if (exp_q.size() > 0) chk("stall_hresp", 32'(m_resp), 32'(exp_q[0].resp));
          lows++;
        end
      end else begin
        chk("idle_hready", 32'(m_ready), 32'd1);
        chk("idle_hresp", 32'(m_resp), 32'd0);
        chk("idle_hrdata", m_rdata, 32'd0);
      end
      if (m_ready) outstanding = (hresetn && hsel[cur] && htrans[1]) ? 1 : 0;
      if (!hresetn) begin
        outstanding = 0;
        lows = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    hresetn = 1'b0; hsel = '0; htrans = 2'b00; haddr = '0; hsize = '0;
    hwrite = 1'b0; hwdata = '0; hburst = '0; pend_wd = '0;
    repeat (3) @(posedge hclk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      chk("reset_hready", 32'(hready[d]), 32'd1);
      chk("reset_hresp", 32'(hresp[d]), 32'd0);
      chk("reset_hrdata", hrdata[d], 32'd0);
    end
    cur = 0;
    hresetn = 1'b1;
    mon_en  = 1;

    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      for (int k = 0; k < 32; k++) present(1'b1, 2'b10, 32'(k * 4), 3'd2, 1'b1, $urandom, 1'b1);
      drain();
    end

    cur = 1;
    present(1'b1, 2'b10, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 1'b1);
    present(1'b1, 2'b10, 32'h10, 3'd2, 1'b0, 32'd0, 1'b1);
    drain();

    cur = 0;
    c0 = cyc;
    present(1'b1, 2'b10, 32'h20, 3'd2, 1'b1, 32'h11223344, 1'b1);
    present(1'b1, 2'b11, 32'h21, 3'd0, 1'b1, 32'h0000AA00, 1'b1);
    present(1'b1, 2'b11, 32'h20, 3'd2, 1'b0, 32'd0, 1'b1);
    chk("zero_wait_throughput", 32'(cyc - c0), 32'd3);
    drain();

    cur = 1;
    present(1'b1, 2'b10, 32'h03, 3'd1, 1'b0, 32'd0, 1'b1);
    present(1'b1, 2'b10, 32'h10, 3'd3, 1'b1, 32'h01010101, 1'b1);
    present(1'b1, 2'b10, 32'h1000, 3'd2, 1'b1, 32'h02020202, 1'b1);
    present(1'b1, 2'b10, 32'h10, 3'd2, 1'b0, 32'd0, 1'b1);
    drain();
    for (int i = 0; i < 10; i++)
      present(1'b1, 2'(i % 2), 32'h10, 3'd2, 1'b1, $urandom, 1'b1);
    present(1'b1, 2'b10, 32'h10, 3'd2, 1'b0, 32'd0, 1'b1);
    drain();

    cur = 2;
    present(1'b1, 2'b10, 32'h40, 3'd2, 1'b1, 32'h01234567, 1'b1);
    drain();
    present(1'b1, 2'b10, 32'h40, 3'd2, 1'b1, 32'h5555AAAA, 1'b0);
    @(posedge hclk); #1;
    hresetn = 1'b0; hsel = '0; htrans = 2'b00;
    @(posedge hclk); #1;
    chk("abort_hready", 32'(hready[2]), 32'd1);
    chk("abort_hresp", 32'(hresp[2]), 32'd0);
    chk("abort_hrdata", hrdata[2], 32'd0);
    hresetn = 1'b1;
    present(1'b1, 2'b10, 32'h40, 3'd2, 1'b0, 32'd0, 1'b1);
    drain();

    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      for (int n = 0; n < 150; n++) rand_xfer();
      drain();
    end

    repeat (2) @(posedge hclk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_lite_ram_slave.md
AHB_LITE_RAM_SLAVE -- requirements
Module: ahb_lite_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width; capacity 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15; HREADY-low cycles inserted per OKAY transfer.
REQ-003 SHALL have a single clock and a synchronous, active-low reset.
REQ-004 HCLK  in  1  clock; all logic on rising edge.
REQ-005 HRESETn  in  1  synchronous active-low reset.
REQ-006 HADDR  in  32  byte address.
REQ-007 HBURST  in  3  burst type; ignored.
REQ-008 HSEL  in  1  slave select.
REQ-009 HSIZE  in  3  transfer size: 0 byte, 1 halfword, 2 word.
REQ-010 HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-011 HWDATA  in  32  write data, valid in data phase.
REQ-012 HWRITE  in  1  1 write, 0 read.
REQ-013 HRDATA  out  32  read data.
REQ-014 HREADY  out  1  transfer complete / bus ready.
REQ-015 HRESP  out  1  0 OKAY, 1 ERROR.

Function
REQ-016 Address phase accepted when HSEL=1, HREADY=1, HTRANS[1]=1; HADDR, HSIZE, HWRITE registered; SEQ handled as NONSEQ.
REQ-017 HSEL=0 or HTRANS IDLE/BUSY while HREADY=1: no transfer, HREADY stays 1, HRESP 0.
REQ-018 FSM states IDLE, WAIT, DONE, ERR1, ERR2.
REQ-019 IDLE -> WAIT on valid accept with WAIT_STATES>0 (counter loaded with WAIT_STATES); -> DONE with WAIT_STATES=0; -> ERR1 on illegal accept.
REQ-020 WAIT: HREADY=0, counter decrements; -> DONE when counter reaches 1.
REQ-021 DONE: HREADY=1, HRESP=0; transfer completes; new accept in same cycle follows REQ-019, else -> IDLE.
REQ-022 Illegal: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0; HADDR[31:ADDR_BITS+2] nonzero.
REQ-023 ERR1: HRESP=1, HREADY=0; ERR2: HRESP=1, HREADY=1; ERR2 -> IDLE (or accept per REQ-019); no wait states, no memory write.
REQ-024 Write: HWDATA sampled at DONE edge, written with byte enables: HSIZE 0 -> lane HADDR[1:0]; HSIZE 1 -> lanes {HADDR[1],x}; HSIZE 2 -> all four.
REQ-025 Read: HRDATA = full 32-bit word at registered address during DONE; 0 in all other cycles.
REQ-026 Read accepted in the DONE cycle of a write to the same word SHALL return post-write data (forwarding per byte lane), any WAIT_STATES.
REQ-027 Back-to-back OKAY transfers at WAIT_STATES=0 SHALL sustain one transfer per cycle.
REQ-028 HBURST ignored; bursts are sequences of single transfers, no address wrap generated internally.
REQ-029 Memory contents unknown after configuration; never cleared by reset.

Reset
REQ-030 While HRESETn=0 at a clock edge: state IDLE, HREADY=1, HRESP=0, HRDATA=0, counter 0, no memory write.
REQ-031 Reset asserted mid-WAIT or mid-ERR1: pending transfer aborted, no write, outputs per REQ-030 next cycle.
REQ-032 First address phase accepted on first edge with HRESETn=1.

Verification
REQ-033 WAIT_STATES=1: write word 0x0000_0010 = 0xDEADBEEF, then read -> HREADY low 1 cycle per transfer, HRDATA=0xDEADBEEF in read DONE, HRESP=0.
REQ-034 WAIT_STATES=0: word write 0x11223344 to 0x20, byte write 0xAA to 0x21 (HWDATA=0x0000AA00), immediate read 0x20 -> 0x1122AA44 with no stall.
REQ-035 Halfword read at 0x03 -> ERR1 (HRESP=1,HREADY=0) then ERR2 (HRESP=1,HREADY=1); HSIZE=3 and HADDR=0x0000_1000 (ADDR_BITS=10) -> same; memory unchanged.
REQ-036 HSEL=1 with HTRANS=IDLE and BUSY for 5 cycles -> HREADY=1, HRESP=0, HRDATA=0, no writes.
REQ-037 WAIT_STATES=3: assert HRESETn=0 during second WAIT cycle of write 0x5555AAAA to 0x40 -> outputs reset next cycle; subsequent read of 0x40 returns prior contents.
REQ-038 Randomized single/burst reads/writes, sizes 0..2, against a byte-array reference model -> all HRDATA match, HRESP only on illegal transfers.
